uart_can_frame_scheduler: RTL and testbench

UART_CAN_FRAME_SCHEDULER -- requirements
Module: uart_can_frame_scheduler

---
 rtl/bridge_pkg.sv | 23 ++
 rtl/bridge_idle_timer.sv | 30 +++
 rtl/uart_can_frame_scheduler.sv | 143 ++++++++++++++
 tb/tb_uart_can_frame_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the UART-to-CAN frame scheduler: state encoding,
// frame geometry and small helpers.
package bridge_pkg;

  localparam int CAN_MAX_BYTES = 8;
  localparam int CAN_ID_W      = 11;
  localparam int TIMEOUT_W     = 16;
  localparam int CAN_DLC_W     = 4;
  localparam int CAN_DATA_W    = 8 * CAN_MAX_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LOAD    = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  // Saturating 8-bit increment, used by the dropped-byte counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bridge_idle_timer.sv
// Idle-cycle timer: counts enabled cycles, saturates at all-ones, and flags
// expiry when this cycle would complete 'limit' idle cycles (limit 0 = never).
module bridge_idle_timer
  import bridge_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] r_count;
  logic [TIMEOUT_W:0]   w_next;

  // One extra bit so count+1 at saturation still compares correctly.
  assign w_next  = {1'b0, r_count} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign expired = enable && (limit != '0) && (w_next >= {1'b0, limit});

  // Idle counter: clear wins, otherwise count enabled cycles up to saturation.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != '1)) begin
      r_count <= w_next[TIMEOUT_W-1:0];
    end
  end

endmodule

// File: rtl/uart_can_frame_scheduler.sv
// Packs UART RX bytes into CAN frames of up to 8 bytes. A frame is launched
// when 8 bytes are collected or the line has been idle for cfg_timeout cycles.
//
// Handshakes: rx_byte_valid is a one-cycle pulse with no back-pressure (bytes
// that cannot be stored are counted in drop_count). can_load is a one-cycle
// pulse issued only while can_busy is low; frame fields stay stable until the
// transmitter returns the one-cycle can_done pulse, which frees the buffer.
module uart_can_frame_scheduler
  import bridge_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_byte_valid,
  input  logic [7:0]            rx_byte,
  input  logic [CAN_ID_W-1:0]   cfg_can_id,
  input  logic [TIMEOUT_W-1:0]  cfg_timeout,
  input  logic                  can_busy,
  input  logic                  can_done,
  output logic                  can_load,
  output logic [CAN_ID_W-1:0]   can_id,
  output logic [CAN_DLC_W-1:0]  can_dlc,
  output logic [CAN_DATA_W-1:0] can_data,
  output logic                  frame_pending,
  output logic [7:0]            drop_count,
  output state_t                dbg_state
);

  state_t                r_state;
  logic [CAN_DLC_W-1:0]  r_count;
  logic [CAN_DATA_W-1:0] r_buf;
  logic                  r_can_load;
  logic [CAN_ID_W-1:0]   r_can_id;
  logic [CAN_DLC_W-1:0]  r_can_dlc;
  logic [CAN_DATA_W-1:0] r_can_data;
  logic [7:0]            r_drop_count;

  logic                  w_timer_en;
  logic                  w_timer_clear;
  logic                  w_expired;
  logic [2:0]            w_idx;
  logic [CAN_DATA_W-1:0] w_buf_store;

  // Timer runs only on idle COLLECT cycles; anything else restarts it.
  assign w_timer_en    = (r_state == ST_COLLECT) && !rx_byte_valid;
  assign w_timer_clear = !w_timer_en;

  bridge_idle_timer u_idle_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .limit   (cfg_timeout),
    .expired (w_expired)
  );

  // Buffer with the incoming byte placed at slot 'count' (byte 0 in the MSBs).
  assign w_idx = r_count[2:0];
  always_comb begin
    w_buf_store = r_buf;
    w_buf_store[{3'd7 - w_idx, 3'b000} +: 8] = rx_byte;
  end

  // Frame scheduler FSM with registered frame fields and load strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_buf        <= '0;
      r_can_load   <= 1'b0;
      r_can_id     <= '0;
      r_can_dlc    <= '0;
      r_can_data   <= '0;
      r_drop_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rx_byte_valid) begin
            r_buf   <= {rx_byte, {(CAN_DATA_W-8){1'b0}}};
            r_count <= 4'd1;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (rx_byte_valid) begin
            r_buf   <= w_buf_store;
            r_count <= r_count + 4'd1;
            if (r_count == 4'(CAN_MAX_BYTES - 1)) begin
              r_can_id   <= cfg_can_id;
              r_can_dlc  <= 4'(CAN_MAX_BYTES);
              r_can_data <= w_buf_store;
              r_can_load <= !can_busy;
              r_state    <= ST_LOAD;
            end
          end else if (w_expired) begin
            r_can_id   <= cfg_can_id;
            r_can_dlc  <= r_count;
            r_can_data <= r_buf;
            r_can_load <= !can_busy;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // The strobe is high for exactly the one cycle before WAIT.
          if (r_can_load) begin
            r_can_load <= 1'b0;
            r_state    <= ST_WAIT;
          end else if (!can_busy) begin
            r_can_load <= 1'b1;
          end
          if (rx_byte_valid) begin
            r_drop_count <= sat_inc8(r_drop_count);
          end
        end
        ST_WAIT: begin
          if (can_done) begin
            // A byte landing with can_done opens the next frame immediately.
            if (rx_byte_valid) begin
              r_buf   <= {rx_byte, {(CAN_DATA_W-8){1'b0}}};
              r_count <= 4'd1;
              r_state <= ST_COLLECT;
            end else begin
              r_buf   <= '0;
              r_count <= '0;
              r_state <= ST_IDLE;
            end
          end else if (rx_byte_valid) begin
            r_drop_count <= sat_inc8(r_drop_count);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign can_load      = r_can_load;
  assign can_id        = r_can_id;
  assign can_dlc       = r_can_dlc;
  assign can_data      = r_can_data;
  assign drop_count    = r_drop_count;
  assign frame_pending = (r_state == ST_LOAD) || (r_state == ST_WAIT);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_can_frame_scheduler.sv
// Directed bench for uart_can_frame_scheduler with a frame scoreboard.
module tb_uart_can_frame_scheduler;
  import bridge_pkg::*;

  localparam int FW = CAN_ID_W + CAN_DLC_W + CAN_DATA_W;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic [10:0] cfg_can_id;
  logic [15:0] cfg_timeout;
  logic        can_busy;
  logic        can_done;
  logic        can_load;
  logic [10:0] can_id;
  logic [3:0]  can_dlc;
  logic [63:0] can_data;
  logic        frame_pending;
  logic [7:0]  drop_count;
  state_t      dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  uart_can_frame_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte       (rx_byte),
    .cfg_can_id    (cfg_can_id),
    .cfg_timeout   (cfg_timeout),
    .can_busy      (can_busy),
    .can_done      (can_done),
    .can_load      (can_load),
    .can_id        (can_id),
    .can_dlc       (can_dlc),
    .can_data      (can_data),
    .frame_pending (frame_pending),
    .drop_count    (drop_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int load_count = 0;
  int last_load_cyc = -1;
  int last_valid_cyc = 0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every can_load pops one expected {id, dlc, data} frame.
  always @(negedge clock) begin
    if (can_load === 1'b1) begin
      load_count++;
      last_load_cyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_load: observed id=%0h dlc=%0d data=%0h expected no frame",
               can_id, can_dlc, can_data);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checks++;
        assert ({can_id, can_dlc, can_data} === mon_exp) else begin
          errors++;
          $error("FAIL frame: observed %0h expected %0h", {can_id, can_dlc, can_data}, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_valid = 1'b1;
    rx_byte       = b;
    last_valid_cyc = cyc;
    tick();
    rx_byte_valid = 1'b0;
    rx_byte       = 8'h00;
  endtask

  task automatic pulse_done();
    can_done = 1'b1;
    tick();
    can_done = 1'b0;
  endtask

  // Waits for the next can_load within a cycle budget; leaves the bench
  // aligned just after the following rising edge.
  task automatic wait_load(input int budget, input string tag);
    int start;
    start = load_count;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (load_count != start) break;
    end
    check(tag, 64'(load_count - start), 64'd1);
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_load"},    64'(can_load),      64'd0);
    check({tag, "_pending"}, 64'(frame_pending), 64'd0);
    check({tag, "_id"},      64'(can_id),        64'd0);
    check({tag, "_dlc"},     64'(can_dlc),       64'd0);
    check({tag, "_data"},    can_data,           64'd0);
    check({tag, "_drop"},    64'(drop_count),    64'd0);
    check({tag, "_state"},   64'(dbg_state),     64'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int start;
    int busy_fall_cyc;
    logic [63:0] exp_data;
    logic [7:0]  b;

    // Reset wins over a simultaneous byte and can_done.
    reset = 1'b1; rx_byte_valid = 1'b1; rx_byte = 8'hEE;
    cfg_can_id = 11'h000; cfg_timeout = 16'd0; can_busy = 1'b0; can_done = 1'b1;
    repeat (3) tick();
    check_zero_outputs("reset");
    reset = 1'b0; rx_byte_valid = 1'b0; rx_byte = 8'h00; can_done = 1'b0;
    tick();

    // can_done outside WAIT is ignored.
    pulse_done();
    check("done_in_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Full 8-byte frame, load the cycle after the 8th byte.
    cfg_can_id = 11'h123;
    exp_q.push_back({11'h123, 4'd8, 64'h1122_3344_5566_7788});
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11));
    wait_load(5, "full_load_seen");
    check("full_latency", 64'(last_load_cyc), 64'(last_valid_cyc + 1));
    check("full_wait_state", 64'(dbg_state), 64'(ST_WAIT));
    check("full_wait_pending", 64'(frame_pending), 64'd1);
    check("full_held_dlc", 64'(can_dlc), 64'd8);
    pulse_done();
    check("full_done_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("full_done_pending", 64'(frame_pending), 64'd0);

    // Timeout flush: 10 idle cycles after the last byte, then the load.
    cfg_can_id = 11'h2AA; cfg_timeout = 16'd10;
    exp_q.push_back({11'h2AA, 4'd3, 64'hA1A2_A300_0000_0000});
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    wait_load(30, "timeout_load_seen");
    check("timeout_latency", 64'(last_load_cyc), 64'(last_valid_cyc + 1 + 10));
    pulse_done();

    // A byte in the cycle the timeout would fire is kept and restarts the timer.
    cfg_can_id = 11'h0F0; cfg_timeout = 16'd3;
    exp_q.push_back({11'h0F0, 4'd2, 64'hC1C2_0000_0000_0000});
    send_byte(8'hC1);
    tick(); tick();
    send_byte(8'hC2);
    check("edge_byte_kept", 64'(dbg_state), 64'(ST_COLLECT));
    wait_load(20, "edge_load_seen");
    check("edge_latency", 64'(last_load_cyc), 64'(last_valid_cyc + 1 + 3));
    pulse_done();

    // Busy transmitter: load held off, fields stable, strobe after busy falls.
    cfg_can_id = 11'h555; cfg_timeout = 16'd0; can_busy = 1'b1;
    exp_q.push_back({11'h555, 4'd8, 64'h0102_0304_0506_0708});
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    start = load_count;
    for (int i = 0; i < 20; i++) begin
      check("busy_data_stable", can_data, 64'h0102_0304_0506_0708);
      tick();
    end
    check("busy_no_load", 64'(load_count - start), 64'd0);
    check("busy_state", 64'(dbg_state), 64'(ST_LOAD));
    can_busy = 1'b0;
    busy_fall_cyc = cyc;
    wait_load(5, "busy_load_seen");
    check("busy_latency", 64'(last_load_cyc), 64'(busy_fall_cyc + 1));

    // Bytes during WAIT are dropped; counter saturates; frame fields untouched.
    cfg_can_id = 11'h321;
    for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)));
    check("drop_sat", 64'(drop_count), 64'd255);
    check("drop_data_held", can_data, 64'h0102_0304_0506_0708);
    check("drop_id_held", 64'(can_id), 64'h555);
    check("drop_dlc_held", 64'(can_dlc), 64'd8);
    check("drop_state", 64'(dbg_state), 64'(ST_WAIT));

    // Byte together with can_done starts a new frame as byte 0.
    exp_q.push_back({11'h321, 4'd8, 64'h5A61_6263_6465_6667});
    can_done = 1'b1;
    send_byte(8'h5A);
    can_done = 1'b0;
    check("done_byte_state", 64'(dbg_state), 64'(ST_COLLECT));
    for (int i = 1; i <= 7; i++) send_byte(8'(8'h60 + i));
    wait_load(5, "done_byte_load_seen");
    pulse_done();

    // Reset mid-frame discards everything, then a clean frame follows.
    cfg_can_id = 11'h7FF;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
    start = load_count;
    reset = 1'b1; rx_byte_valid = 1'b1; rx_byte = 8'h99;
    tick();
    reset = 1'b0; rx_byte_valid = 1'b0; rx_byte = 8'h00;
    check_zero_outputs("midreset");
    repeat (10) tick();
    check("midreset_no_load", 64'(load_count - start), 64'd0);
    exp_data = '0;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_data = {exp_data[55:0], b};
    end
    exp_q.push_back({11'h7FF, 4'd8, exp_data});
    for (int i = 7; i >= 0; i--) send_byte(exp_data[i*8 +: 8]);
    wait_load(5, "midreset_load_seen");
    pulse_done();

    // Timeout disabled: a partial frame waits indefinitely.
    cfg_timeout = 16'd0;
    send_byte(8'hD1); send_byte(8'hD2);
    start = load_count;
    repeat (70000) tick();
    check("no_timeout_load", 64'(load_count - start), 64'd0);
    check("no_timeout_state", 64'(dbg_state), 64'(ST_COLLECT));

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
